// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the local memory subsystem: arbiter state encoding,
// requester indices and a byte-lane masking helper.
package sram_port_arbiter_pkg;

  typedef enum logic {
    StIdle     = 1'b0,
    StReadWait = 1'b1
  } arb_state_e;

  localparam logic REQ_CORE       = 1'b0;
  localparam logic REQ_MANAGEMENT = 1'b1;

  // Zero every byte lane whose select bit is clear.
  function automatic logic [31:0] lane_mask(input logic [31:0] data, input logic [3:0] sel);
    logic [31:0] masked;
    masked = '0;
    for (int i = 0; i < 4; i++) begin
      masked[8*i +: 8] = sel[i] ? data[8*i +: 8] : 8'h00;
    end
    return masked;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_round_robin_grant.sv
// Two-input round-robin grant: a lone requester wins, on contention the
// requester that was not granted last wins.
module round_robin_grant
  import sram_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       winner,
  output logic       grant_valid
);

  logic last_grant_q;

  always_comb begin
    grant_valid = |req;
    if (req == 2'b11) begin
      winner = ~last_grant_q;
    end else if (req[REQ_MANAGEMENT]) begin
      winner = REQ_MANAGEMENT;
    end else begin
      winner = REQ_CORE;
    end
  end

  // Management counts as last granted so the core wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= REQ_MANAGEMENT;
    end else if (advance && grant_valid) begin
      last_grant_q <= winner;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM (1-cycle registered read) between the core and
// management memory interfaces, with round-robin grant and window faulting.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 9,
  parameter logic [31:0] BASE_ADDRESS  = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              core_memoryAddress,
  input  logic [3:0]               core_memoryByteSelect,
  input  logic                     core_memoryWriteEnable,
  input  logic                     core_memoryReadEnable,
  input  logic [31:0]              core_memoryDataWrite,
  output logic [31:0]              core_memoryDataRead,
  output logic                     core_memoryBusy,
  output logic                     core_memoryAccessFault,
  input  logic [31:0]              management_memoryAddress,
  input  logic [3:0]               management_memoryByteSelect,
  input  logic                     management_memoryWriteEnable,
  input  logic                     management_memoryReadEnable,
  input  logic [31:0]              management_memoryDataWrite,
  output logic [31:0]              management_memoryDataRead,
  output logic                     management_memoryBusy,
  output logic                     management_memoryAccessFault,
  output logic                     sram_csb0,
  output logic                     sram_web0,
  output logic [3:0]               sram_wmask0,
  output logic [ADDRESS_WIDTH-1:0] sram_addr0,
  output logic [31:0]              sram_din0,
  input  logic [31:0]              sram_dout0
);

  localparam int unsigned Lsb = ADDRESS_WIDTH + 2;

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       winner, grant_valid;

  logic [31:0] addr  [2];
  logic [3:0]  sel   [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [1:0]  re, we, req, valid, busy, fault;

  assign addr[REQ_CORE]        = core_memoryAddress;
  assign addr[REQ_MANAGEMENT]  = management_memoryAddress;
  assign sel[REQ_CORE]         = core_memoryByteSelect;
  assign sel[REQ_MANAGEMENT]   = management_memoryByteSelect;
  assign wdata[REQ_CORE]       = core_memoryDataWrite;
  assign wdata[REQ_MANAGEMENT] = management_memoryDataWrite;
  assign re = {management_memoryReadEnable, core_memoryReadEnable};
  assign we = {management_memoryWriteEnable, core_memoryWriteEnable};
  assign req = re | we;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      valid[i] = !(re[i] && we[i]) && (sel[i] != 4'b0000) &&
                 (addr[i][31:Lsb] == BASE_ADDRESS[31:Lsb]);
    end
  end

  round_robin_grant u_grant (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .advance     (state_q == StIdle),
    .winner      (winner),
    .grant_valid (grant_valid)
  );

  // Outputs are gated by rst_n so they sit at reset values while it is low.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = 4'b0000;
    sram_addr0  = '0;
    sram_din0   = '0;
    busy        = 2'b00;
    fault       = 2'b00;
    rdata[0]    = '0;
    rdata[1]    = '0;
    if (rst_n) begin
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            busy = req;
            if (!valid[winner]) begin
              fault[winner] = 1'b1;
              busy[winner]  = 1'b0;
            end else if (we[winner]) begin
              sram_csb0    = 1'b0;
              sram_web0    = 1'b0;
              sram_wmask0  = sel[winner];
              sram_addr0   = addr[winner][Lsb-1:2];
              sram_din0    = wdata[winner];
              busy[winner] = 1'b0;
            end else begin
              sram_csb0    = 1'b0;
              sram_addr0   = addr[winner][Lsb-1:2];
              busy[winner] = 1'b1;
              owner_d      = winner;
              state_d      = StReadWait;
            end
          end
        end
        StReadWait: begin
          busy          = req;
          busy[owner_q] = 1'b0;
          // A dropped read discards the returned word.
          if (re[owner_q]) begin
            rdata[owner_q] = lane_mask(sram_dout0, sel[owner_q]);
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= REQ_CORE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign core_memoryDataRead          = rdata[REQ_CORE];
  assign management_memoryDataRead    = rdata[REQ_MANAGEMENT];
  assign core_memoryBusy              = busy[REQ_CORE];
  assign management_memoryBusy        = busy[REQ_MANAGEMENT];
  assign core_memoryAccessFault       = fault[REQ_CORE];
  assign management_memoryAccessFault = fault[REQ_MANAGEMENT];

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a behavioural
// 512x32 SRAM model (registered read, byte-masked write).
module tb_sram_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] c_addr, m_addr, c_wdata, m_wdata, c_rdata, m_rdata;
  logic [3:0]  c_sel, m_sel;
  logic        c_we, c_re, m_we, m_re;
  logic        c_busy, m_busy, c_fault, m_fault;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0, sram_dout0;
  logic [31:0] mem [512];

  int n_checks = 0;
  int n_fail   = 0;

  sram_port_arbiter dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .core_memoryAddress           (c_addr),
    .core_memoryByteSelect        (c_sel),
    .core_memoryWriteEnable       (c_we),
    .core_memoryReadEnable        (c_re),
    .core_memoryDataWrite         (c_wdata),
    .core_memoryDataRead          (c_rdata),
    .core_memoryBusy              (c_busy),
    .core_memoryAccessFault       (c_fault),
    .management_memoryAddress     (m_addr),
    .management_memoryByteSelect  (m_sel),
    .management_memoryWriteEnable (m_we),
    .management_memoryReadEnable  (m_re),
    .management_memoryDataWrite   (m_wdata),
    .management_memoryDataRead    (m_rdata),
    .management_memoryBusy        (m_busy),
    .management_memoryAccessFault (m_fault),
    .sram_csb0                    (sram_csb0),
    .sram_web0                    (sram_web0),
    .sram_wmask0                  (sram_wmask0),
    .sram_addr0                   (sram_addr0),
    .sram_din0                    (sram_din0),
    .sram_dout0                   (sram_dout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int i = 0; i < 4; i++) begin
          if (sram_wmask0[i]) mem[sram_addr0][8*i +: 8] <= sram_din0[8*i +: 8];
        end
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic core_req(input logic re, input logic we, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d);
    c_re = re; c_we = we; c_addr = a; c_sel = s; c_wdata = d;
  endtask

  task automatic mgmt_req(input logic re, input logic we, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d);
    m_re = re; m_we = we; m_addr = a; m_sel = s; m_wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    mgmt_req(0, 0, 0, 0, 0);
    core_req(1, 0, 32'h10, 4'hF, 0);
    #7;
    check_eq("rst_csb0", {31'd0, sram_csb0}, 1);
    check_eq("rst_web0", {31'd0, sram_web0}, 1);
    check_eq("rst_core_busy", {31'd0, c_busy}, 0);
    check_eq("rst_core_rdata", c_rdata, 0);
    check_eq("rst_addr0", {23'd0, sram_addr0}, 0);
    check_eq("rst_wmask0", {28'd0, sram_wmask0}, 0);
    core_req(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // Preload word 2 = 0 and word 4 = DEADBEEF through management writes.
    mgmt_req(0, 1, 32'h8, 4'hF, 32'h0);
    settle();
    check_eq("pre_m_busy", {31'd0, m_busy}, 0);
    tick();
    mgmt_req(0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
    settle();
    check_eq("pre_addr0", {23'd0, sram_addr0}, 4);
    check_eq("pre_web0", {31'd0, sram_web0}, 0);
    tick();
    mgmt_req(0, 0, 0, 0, 0);

    // Lone core read.
    core_req(1, 0, 32'h10, 4'hF, 0);
    settle();
    check_eq("rd_busy_n", {31'd0, c_busy}, 1);
    check_eq("rd_csb0_n", {31'd0, sram_csb0}, 0);
    check_eq("rd_web0_n", {31'd0, sram_web0}, 1);
    check_eq("rd_addr0_n", {23'd0, sram_addr0}, 4);
    check_eq("rd_data_n", c_rdata, 0);
    tick();
    settle();
    check_eq("rd_data_n1", c_rdata, 32'hDEADBEEF);
    check_eq("rd_busy_n1", {31'd0, c_busy}, 0);
    check_eq("rd_csb0_n1", {31'd0, sram_csb0}, 1);
    tick();
    core_req(0, 0, 0, 0, 0);

    // Partial management write then core readback.
    mgmt_req(0, 1, 32'h8, 4'b0011, 32'h12345678);
    settle();
    check_eq("wr_m_busy", {31'd0, m_busy}, 0);
    check_eq("wr_web0", {31'd0, sram_web0}, 0);
    check_eq("wr_wmask0", {28'd0, sram_wmask0}, 4'b0011);
    check_eq("wr_addr0", {23'd0, sram_addr0}, 2);
    check_eq("wr_din0", sram_din0, 32'h12345678);
    tick();
    mgmt_req(0, 0, 0, 0, 0);
    core_req(1, 0, 32'h8, 4'hF, 0);
    settle();
    check_eq("wrb_busy_n", {31'd0, c_busy}, 1);
    tick();
    settle();
    check_eq("wrb_data", c_rdata, 32'h00005678);
    tick();
    core_req(1, 0, 32'h10, 4'b0011, 0);
    tick();
    settle();
    check_eq("lane_mask_data", c_rdata, 32'h0000BEEF);
    tick();
    core_req(0, 0, 0, 0, 0);

    // Contending reads right after reset: core first, then management.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    core_req(1, 0, 32'h10, 4'hF, 0);
    mgmt_req(1, 0, 32'h8, 4'hF, 0);
    settle();
    check_eq("both_c1_cbusy", {31'd0, c_busy}, 1);
    check_eq("both_c1_mbusy", {31'd0, m_busy}, 1);
    check_eq("both_c1_addr0", {23'd0, sram_addr0}, 4);
    tick();
    settle();
    check_eq("both_c2_cdata", c_rdata, 32'hDEADBEEF);
    check_eq("both_c2_cbusy", {31'd0, c_busy}, 0);
    check_eq("both_c2_mbusy", {31'd0, m_busy}, 1);
    check_eq("both_c2_mdata", m_rdata, 0);
    tick();
    core_req(0, 0, 0, 0, 0);
    settle();
    check_eq("both_c3_mbusy", {31'd0, m_busy}, 1);
    check_eq("both_c3_addr0", {23'd0, sram_addr0}, 2);
    check_eq("both_c3_csb0", {31'd0, sram_csb0}, 0);
    tick();
    settle();
    check_eq("both_c4_mdata", m_rdata, 32'h00005678);
    check_eq("both_c4_mbusy", {31'd0, m_busy}, 0);
    tick();
    mgmt_req(0, 0, 0, 0, 0);

    // Continuous contending writes alternate every cycle, core first.
    core_req(0, 1, 32'h20, 4'hF, 32'hAAAA0001);
    mgmt_req(0, 1, 32'h24, 4'hF, 32'hBBBB0002);
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq($sformatf("alt_addr0_%0d", i), {23'd0, sram_addr0}, (i % 2 == 0) ? 8 : 9);
      check_eq($sformatf("alt_cbusy_%0d", i), {31'd0, c_busy}, (i % 2 == 0) ? 0 : 1);
      check_eq($sformatf("alt_mbusy_%0d", i), {31'd0, m_busy}, (i % 2 == 0) ? 1 : 0);
      tick();
    end
    core_req(0, 0, 0, 0, 0);
    mgmt_req(0, 0, 0, 0, 0);

    // Faults: out of window, read+write together, empty byte select.
    core_req(1, 0, 32'h800, 4'hF, 0);
    settle();
    check_eq("flt_win_fault", {31'd0, c_fault}, 1);
    check_eq("flt_win_busy", {31'd0, c_busy}, 0);
    check_eq("flt_win_csb0", {31'd0, sram_csb0}, 1);
    check_eq("flt_win_mfault", {31'd0, m_fault}, 0);
    tick();
    core_req(1, 1, 32'h10, 4'hF, 0);
    settle();
    check_eq("flt_rw_fault", {31'd0, c_fault}, 1);
    check_eq("flt_rw_busy", {31'd0, c_busy}, 0);
    check_eq("flt_rw_csb0", {31'd0, sram_csb0}, 1);
    tick();
    core_req(1, 0, 32'h10, 4'h0, 0);
    settle();
    check_eq("flt_sel_fault", {31'd0, c_fault}, 1);
    tick();
    core_req(0, 0, 0, 0, 0);
    settle();
    check_eq("flt_idle_fault", {31'd0, c_fault}, 0);
    tick();

    // Reset during READ_WAIT aborts the read; re-request completes.
    core_req(1, 0, 32'h10, 4'hF, 0);
    settle();
    check_eq("rrw_busy_n", {31'd0, c_busy}, 1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rrw_rst_data", c_rdata, 0);
    check_eq("rrw_rst_busy", {31'd0, c_busy}, 0);
    check_eq("rrw_rst_csb0", {31'd0, sram_csb0}, 1);
    rst_n = 1'b1;
    settle();
    check_eq("rrw_again_busy", {31'd0, c_busy}, 1);
    check_eq("rrw_again_csb0", {31'd0, sram_csb0}, 0);
    tick();
    settle();
    check_eq("rrw_again_data", c_rdata, 32'hDEADBEEF);
    check_eq("rrw_again_done", {31'd0, c_busy}, 0);
    tick();
    core_req(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port synchronous SRAM macro (1-cycle registered read) between the RV32I core memory interface and the management memory interface. Each requester uses the core's native memory handshake (address, byteSelect, read/write enable, busy, accessFault). The arbiter round-robins between the two requesters, sequences the SRAM read latency, and faults addresses outside its window. It sits between RV32ICore/management and the SRAM macro in the core's local memory subsystem.

## Interface

- ADDRESS_WIDTH, 9, SRAM word-address width (512 x 32 bit)
- BASE_ADDRESS, 32'h0000_0000, byte base of the SRAM window; low ADDRESS_WIDTH+2 bits ignored

- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- core_memoryAddress / management_memoryAddress  input  32  byte address
- core_memoryByteSelect / management_memoryByteSelect  input  4  byte-lane mask
- core_memoryWriteEnable / management_memoryWriteEnable  input  1  write request
- core_memoryReadEnable / management_memoryReadEnable  input  1  read request
- core_memoryDataWrite / management_memoryDataWrite  input  32  write data
- core_memoryDataRead / management_memoryDataRead  output  32  read data, valid when busy low on a read
- core_memoryBusy / management_memoryBusy  output  1  request not yet complete; hold request stable
- core_memoryAccessFault / management_memoryAccessFault  output  1  request rejected, single cycle
- sram_csb0  output  1  chip select, active low
- sram_web0  output  1  write enable, active low
- sram_wmask0  output  4  byte write mask
- sram_addr0  output  ADDRESS_WIDTH  word address (address[ADDRESS_WIDTH+1:2])
- sram_din0  output  32  write data
- sram_dout0  input  32  read data, valid the cycle after a read select

## Operation

- Request = readEnable | writeEnable. readEnable & writeEnable together, or address[31:ADDRESS_WIDTH+2] != BASE_ADDRESS[31:ADDRESS_WIDTH+2], or byteSelect == 0: invalid.
- Invalid request when it would be granted: accessFault=1, busy=0 for that cycle, no SRAM access, counts as a grant for round-robin.
- States: IDLE, READ_WAIT.
- IDLE: if one requester requests, it wins; if both, winner = requester not in lastGrant. Winner's valid write: csb0=0, web0=0, wmask0=byteSelect, busy=0 (write completes at this edge), stay IDLE. Winner's valid read: csb0=0, web0=1, busy=1, record owner, -> READ_WAIT. lastGrant <= winner. Loser: busy=1.
- READ_WAIT: csb0=1 (no new access). Owner: dataRead = sram_dout0 with unselected lanes zeroed, busy=0. Other requester: busy=1. -> IDLE unconditionally. If owner dropped its request, data discarded, still -> IDLE.
- dataRead is 0 whenever the port is not completing a read. accessFault is 0 except as above.
- Address bits [1:0] ignored; byteSelect is the lane mask directly.
- Throughput: writes 1/cycle, reads 1 per 2 cycles; two contending requesters alternate strictly.

## Timing

- Reset (rst_n low, asynchronous): state=IDLE, lastGrant=management (core wins first contention), owner cleared; csb0=1, web0=1, wmask0=0, addr0=0, din0=0; both busy=0, both accessFault=0, both dataRead=0 while rst_n low.
- Reset mid READ_WAIT: read aborted, no data returned; after release, requester re-presents.
- busy, accessFault and SRAM outputs are combinational from state and requests; state/lastGrant/owner are registered.
- Read latency: request cycle N (busy=1), data and busy=0 in cycle N+1.
- Write latency: busy=0 in request cycle; SRAM captures at that clock edge.
- Requester must hold address/enables/data stable while busy=1.

## Structure

- Shared package (memory subsystem package): state encoding (IDLE, READ_WAIT), requester index constants (REQ_CORE=0, REQ_MANAGEMENT=1).
- One natural sub-module: round_robin_grant (2-input, lastGrant register, outputs winner index and grant valid); remainder inline.

## Test plan

- Core read 0x0000_0010 alone, SRAM word 4 = 0xDEADBEEF -> cycle N busy=1, csb0=0, addr0=4; N+1 core_memoryDataRead=0xDEADBEEF, busy=0.
- Management write 0x1234_5678, byteSelect 4'b0011, address 0x8 -> same cycle busy=0, web0=0, wmask0=4'b0011, addr0=2; subsequent core read of 0x8 returns 0x0000_5678 given prior 0.
- Both read simultaneously after reset -> core served first (2 cycles), management next; management busy=1 for 2 cycles, then 2-cycle read.
- Both issue back-to-back writes continuously -> grants alternate core, management, core each cycle.
- Core read 0x0000_0800 (ADDRESS_WIDTH=9) -> accessFault=1, busy=0 same cycle, csb0=1; same for read&write both high.
- rst_n dropped in READ_WAIT -> all outputs at reset values immediately; after release, core re-request completes normally in 2 cycles.
